tpu_result_drain: RTL

// - Downstream of the systolic array: captures 48-bit result rows (3 lanes x 16 b) into a row FIFO.
// - Serves the rows to the Caravel Wishbone bus as 32-bit words. Also exposes a status/control register.
// - Replaces fixed-slot result readout with a flow-controlled drain, so rows are never overwritten silently.

---
 rtl/tpu_result_drain_pkg.sv | 39 +++
 rtl/tpu_result_drain_row_fifo.sv | 59 +++++
 rtl/tpu_result_drain.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tpu_result_drain_pkg.sv
// Shared constants, access decode type and status-word packing for the
// systolic-array result drain.
package tpu_result_drain_pkg;

  localparam int LANES     = 3;
  localparam int LANE_W    = 16;
  localparam int ROW_W     = LANES * LANE_W;
  localparam int DEF_DEPTH = 8;

  localparam logic [31:0] DEF_DATA_ADDRESS   = 32'h3000_0004;
  localparam logic [31:0] DEF_STAT_ADDRESS   = 32'h3000_0008;
  localparam logic [31:0] EMPTY_READ_PATTERN = 32'hDEAD_0000;

  localparam int STAT_UDF_BIT   = 7;
  localparam int STAT_OVF_BIT   = 8;
  localparam int STAT_HALF_BIT  = 9;
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_DATA_RD,
    ACC_DATA_WR,
    ACC_STAT_RD,
    ACC_STAT_WR
  } acc_e;

  function automatic logic [31:0] stat_word(input logic half, input logic ovf,
                                            input logic udf, input logic [3:0] count);
    logic [31:0] w;
    w                = '0;
    w[3:0]           = count;
    w[STAT_UDF_BIT]  = udf;
    w[STAT_OVF_BIT]  = ovf;
    w[STAT_HALF_BIT] = half;
    return w;
  endfunction

endpackage

// File: rtl/tpu_result_drain_row_fifo.sv
// Single-clock row FIFO with registered occupancy count and a head that is
// visible combinationally; flush has priority over push and pop.
module tpu_row_fifo
  import tpu_result_drain_pkg::*;
#(
  parameter int WIDTH = ROW_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Drains 48-bit systolic-array result rows through a FIFO onto the Caravel
// Wishbone bus as two 32-bit words per row, plus a status/control register.
module tpu_result_drain
  import tpu_result_drain_pkg::*;
#(
  parameter int          DEPTH        = DEF_DEPTH,
  parameter logic [31:0] DATA_ADDRESS = DEF_DATA_ADDRESS,
  parameter logic [31:0] STAT_ADDRESS = DEF_STAT_ADDRESS
) (
  input  logic             caravel_wb_clk_i,
  input  logic             caravel_wb_rst_i,
  input  logic             res_valid_i,
  input  logic [ROW_W-1:0] res_data_i,
  output logic             res_ready_o,
  input  logic             caravel_wb_stb_i,
  input  logic             caravel_wb_cyc_i,
  input  logic             caravel_wb_we_i,
  input  logic [3:0]       caravel_wb_sel_i,
  input  logic [31:0]      caravel_wb_dat_i,
  input  logic [31:0]      caravel_wb_adr_i,
  output logic             caravel_wb_ack_o,
  output logic [31:0]      caravel_wb_dat_o,
  output logic             rows_avail_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ROW_W-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_clear;
  logic             w_drop;
  logic             w_unused_bits;
  acc_e             w_acc;

  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_half;
  logic             r_ovf;
  logic             r_udf;

  // Blocking on r_ack guarantees exactly one ack per request even if stb stays high.
  always_comb begin
    w_acc = ACC_NONE;
    if (caravel_wb_stb_i && caravel_wb_cyc_i && !r_ack) begin
      if (caravel_wb_adr_i == DATA_ADDRESS)
        w_acc = caravel_wb_we_i ? ACC_DATA_WR : ACC_DATA_RD;
      else if (caravel_wb_adr_i == STAT_ADDRESS)
        w_acc = caravel_wb_we_i ? ACC_STAT_WR : ACC_STAT_RD;
    end
  end

  assign w_flush = (w_acc == ACC_STAT_WR) && caravel_wb_sel_i[0] && caravel_wb_dat_i[CTRL_FLUSH_BIT];
  assign w_clear = (w_acc == ACC_STAT_WR) && caravel_wb_sel_i[0] && caravel_wb_dat_i[CTRL_CLEAR_BIT];
  assign w_push  = res_valid_i && !w_full;
  assign w_drop  = res_valid_i && w_full && !w_flush;
  assign w_pop   = (w_acc == ACC_DATA_RD) && !w_empty && r_half;

  assign w_unused_bits = ^{caravel_wb_sel_i[3:1], caravel_wb_dat_i[31:2]};

  tpu_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (caravel_wb_clk_i),
    .i_rst   (caravel_wb_rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (res_data_i),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_half <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_ack <= (w_acc != ACC_NONE);
      case (w_acc)
        ACC_DATA_RD: begin
          if (w_empty) begin
            r_dat <= EMPTY_READ_PATTERN;
            r_udf <= 1'b1;
          end else if (!r_half) begin
            r_dat  <= w_head[2*LANE_W-1:0];
            r_half <= 1'b1;
          end else begin
            r_dat  <= {16'h0000, w_head[ROW_W-1:2*LANE_W]};
            r_half <= 1'b0;
          end
        end
        ACC_STAT_RD: r_dat <= stat_word(r_half, r_ovf, r_udf, 4'(w_count));
        default: ;
      endcase
      if (w_flush) r_half <= 1'b0;
      if (w_clear) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      // A fresh overflow in the same cycle as a clear is kept, not lost.
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign caravel_wb_ack_o = r_ack;
  assign caravel_wb_dat_o = r_dat;
  assign res_ready_o      = !w_full;
  assign rows_avail_o     = !w_empty;

endmodule
